// File: rtl/stage_mem_wb_pipe_pkg.sv
// Shared types and constants for the memory stage with built-in MEM/WB register.
package stage_mem_pkg;

    // Largest supported number of wait states per load/store.
    localparam int MAX_MEM_LAT = 15;

    // Stage FSM: IDLE accepts a new instruction, BUSY counts wait states.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Width of the wait-state counter (holds 0..MAX_MEM_LAT).
    localparam int CNT_W = clog2(MAX_MEM_LAT + 1);

endpackage

// File: rtl/stage_mem_wb_pipe_if.sv
// Bundle of EX/MEM-side inputs and MEM/WB-side outputs of the memory stage.
//
// Handshake: the upstream stage presents an instruction with valid_MEM=1 and
// must hold every *_MEM field (and valid_MEM) stable for as long as stall_MEM
// is 1; the instruction is taken on the first rising edge where stall_MEM=0.
// valid_WB marks a one-cycle result in the WB register; there is no
// back-pressure from writeback. flush squashes whatever is in the stage.
interface stage_mem_wb_pipe_if #(
    parameter int DATA_W = 8,
    parameter int RD_W   = 3
);
    import stage_mem_pkg::*;

    logic              flush;
    logic              valid_MEM;
    logic              MemRead_MEM;
    logic              MemWrite_MEM;
    logic              ResultSrc_MEM;
    logic              RegWrite_MEM;
    logic [RD_W-1:0]   rd_MEM;
    logic [DATA_W-1:0] alu_result_MEM;
    logic [DATA_W-1:0] write_data_MEM;

    logic              stall_MEM;
    logic              valid_WB;
    logic [DATA_W-1:0] mem_data_WB;
    logic [DATA_W-1:0] alu_result_WB;
    logic              ResultSrc_WB;
    logic              RegWrite_WB;
    logic [RD_W-1:0]   rd_WB;
    logic              addr_fault_WB;

    // FSM state, exported for debug and checkers.
    state_t            state_dbg;

    modport master (
        output flush, valid_MEM, MemRead_MEM, MemWrite_MEM, ResultSrc_MEM,
               RegWrite_MEM, rd_MEM, alu_result_MEM, write_data_MEM,
        input  stall_MEM, valid_WB, mem_data_WB, alu_result_WB, ResultSrc_WB,
               RegWrite_WB, rd_WB, addr_fault_WB, state_dbg
    );

    modport slave (
        input  flush, valid_MEM, MemRead_MEM, MemWrite_MEM, ResultSrc_MEM,
               RegWrite_MEM, rd_MEM, alu_result_MEM, write_data_MEM,
        output stall_MEM, valid_WB, mem_data_WB, alu_result_WB, ResultSrc_WB,
               RegWrite_WB, rd_WB, addr_fault_WB, state_dbg
    );

endinterface

// File: rtl/stage_mem_wb_pipe_dmem_array.sv
// Data memory: DEPTH x DATA_W, synchronous write, asynchronous read,
// synchronous active-low clear of every word.
module dmem_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Clear all words on reset, otherwise write one word when enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/stage_mem_wb_pipe.sv
// Memory stage with integrated MEM/WB register. Loads and stores spend
// MEM_LAT wait states in BUSY while upstream is stalled; non-memory ops
// pass straight into the WB register. Out-of-range or read+write requests
// are flagged as faults and never touch the array.
module stage_mem_wb_pipe
    import stage_mem_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int RD_W    = 3,
    parameter int DEPTH   = 256,
    parameter int MEM_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    stage_mem_wb_pipe_if.slave bus
);

    localparam int             ADDR_W   = clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAT_C  = CNT_W'(MEM_LAT);
    localparam bit             HAS_WAIT = (MEM_LAT > 0);

    // Inputs from the EX/MEM side.
    logic              in_flush;
    logic              in_valid;
    logic              in_read;
    logic              in_write;
    logic              in_rsrc;
    logic              in_regwrite;
    logic [RD_W-1:0]   in_rd;
    logic [DATA_W-1:0] in_alu;
    logic [DATA_W-1:0] in_wdata;

    assign in_flush    = bus.flush;
    assign in_valid    = bus.valid_MEM;
    assign in_read     = bus.MemRead_MEM;
    assign in_write    = bus.MemWrite_MEM;
    assign in_rsrc     = bus.ResultSrc_MEM;
    assign in_regwrite = bus.RegWrite_MEM;
    assign in_rd       = bus.rd_MEM;
    assign in_alu      = bus.alu_result_MEM;
    assign in_wdata    = bus.write_data_MEM;

    // FSM and wait-state counter.
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;
    logic              complete;
    logic              stall_raw;

    // Request latched at accept time, used while BUSY.
    logic              req_read_q;
    logic              req_write_q;
    logic              req_rsrc_q;
    logic              req_regwrite_q;
    logic [RD_W-1:0]   req_rd_q;
    logic [DATA_W-1:0] req_alu_q;
    logic [DATA_W-1:0] req_wdata_q;

    // Instruction currently being worked on: live inputs in IDLE, latched in BUSY.
    logic              cur_read;
    logic              cur_write;
    logic              cur_rsrc;
    logic              cur_regwrite;
    logic [RD_W-1:0]   cur_rd;
    logic [DATA_W-1:0] cur_alu;
    logic [DATA_W-1:0] cur_wdata;
    logic              cur_memop;
    logic              cur_fault;

    // Data memory port.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    // WB register.
    logic              valid_wb_q, valid_wb_d;
    logic [DATA_W-1:0] mem_data_wb_q, mem_data_wb_d;
    logic [DATA_W-1:0] alu_wb_q, alu_wb_d;
    logic              rsrc_wb_q, rsrc_wb_d;
    logic              regwrite_wb_q, regwrite_wb_d;
    logic [RD_W-1:0]   rd_wb_q, rd_wb_d;
    logic              fault_wb_q, fault_wb_d;

    // Select the active instruction fields.
    always_comb begin
        cur_read     = in_read;
        cur_write    = in_write;
        cur_rsrc     = in_rsrc;
        cur_regwrite = in_regwrite;
        cur_rd       = in_rd;
        cur_alu      = in_alu;
        cur_wdata    = in_wdata;
        if (state_q == BUSY) begin
            cur_read     = req_read_q;
            cur_write    = req_write_q;
            cur_rsrc     = req_rsrc_q;
            cur_regwrite = req_regwrite_q;
            cur_rd       = req_rd_q;
            cur_alu      = req_alu_q;
            cur_wdata    = req_wdata_q;
        end
    end

    // A fault is only meaningful for memory accesses.
    assign cur_memop = cur_read | cur_write;
    assign cur_fault = cur_memop &
                       (((cur_alu >> ADDR_W) != '0) | (cur_read & cur_write));
    assign mem_addr  = cur_alu[ADDR_W-1:0];

    // Next-state logic: accept, count wait states, complete; flush wins.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        complete  = 1'b0;
        stall_raw = 1'b0;
        if (in_flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if ((in_read | in_write) && HAS_WAIT) begin
                            accept    = 1'b1;
                            stall_raw = 1'b1;
                            state_d   = BUSY;
                            cnt_d     = CNT_W'(1);
                        end else begin
                            complete = 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == LAT_C) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                        cnt_d    = '0;
                    end else begin
                        stall_raw = 1'b1;
                        cnt_d     = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Stores write only on their completion edge and never when faulting.
    assign mem_we = complete & cur_write & ~cur_fault;

    // WB register next value; fields other than valid hold when nothing completes.
    always_comb begin
        valid_wb_d    = 1'b0;
        mem_data_wb_d = mem_data_wb_q;
        alu_wb_d      = alu_wb_q;
        rsrc_wb_d     = rsrc_wb_q;
        regwrite_wb_d = regwrite_wb_q;
        rd_wb_d       = rd_wb_q;
        fault_wb_d    = fault_wb_q;
        if (complete) begin
            valid_wb_d    = 1'b1;
            mem_data_wb_d = (cur_read && !cur_fault) ? mem_rdata : '0;
            alu_wb_d      = cur_alu;
            rsrc_wb_d     = cur_rsrc;
            regwrite_wb_d = cur_regwrite & ~cur_fault;
            rd_wb_d       = cur_rd;
            fault_wb_d    = cur_fault;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request when a multi-cycle access is accepted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_read_q     <= 1'b0;
            req_write_q    <= 1'b0;
            req_rsrc_q     <= 1'b0;
            req_regwrite_q <= 1'b0;
            req_rd_q       <= '0;
            req_alu_q      <= '0;
            req_wdata_q    <= '0;
        end else if (accept) begin
            req_read_q     <= in_read;
            req_write_q    <= in_write;
            req_rsrc_q     <= in_rsrc;
            req_regwrite_q <= in_regwrite;
            req_rd_q       <= in_rd;
            req_alu_q      <= in_alu;
            req_wdata_q    <= in_wdata;
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_wb_q    <= 1'b0;
            mem_data_wb_q <= '0;
            alu_wb_q      <= '0;
            rsrc_wb_q     <= 1'b0;
            regwrite_wb_q <= 1'b0;
            rd_wb_q       <= '0;
            fault_wb_q    <= 1'b0;
        end else begin
            valid_wb_q    <= valid_wb_d;
            mem_data_wb_q <= mem_data_wb_d;
            alu_wb_q      <= alu_wb_d;
            rsrc_wb_q     <= rsrc_wb_d;
            regwrite_wb_q <= regwrite_wb_d;
            rd_wb_q       <= rd_wb_d;
            fault_wb_q    <= fault_wb_d;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dmem (
        .clk     (clk),
        .rst_n   (reset),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (cur_wdata),
        .rdata_o (mem_rdata)
    );

    // Stall is suppressed while reset is asserted; flush already clears it.
    assign bus.stall_MEM     = stall_raw & reset;
    assign bus.valid_WB      = valid_wb_q;
    assign bus.mem_data_WB   = mem_data_wb_q;
    assign bus.alu_result_WB = alu_wb_q;
    assign bus.ResultSrc_WB  = rsrc_wb_q;
    assign bus.RegWrite_WB   = regwrite_wb_q;
    assign bus.rd_WB         = rd_wb_q;
    assign bus.addr_fault_WB = fault_wb_q;
    assign bus.state_dbg     = state_q;

endmodule
